// File: rtl/eq_pkg.sv
// Shared equalizer constants, mixer state encoding and width helpers.
package eq_pkg;

  localparam int unsigned N_BANDS  = 8;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned GAIN_MAX = 3;
  localparam int unsigned AMP_W    = 18;

  typedef enum logic [1:0] {
    MIX_IDLE  = 2'd0,
    MIX_ACCUM = 2'd1,
    MIX_DONE  = 2'd2
  } mix_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sat_trunc.sv
// Combinational signed saturation from IN_W down to OUT_W with a clip flag.
module sat_trunc #(
  parameter int unsigned IN_W  = 21,
  parameter int unsigned OUT_W = 16
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o,
  output logic             clip_o
);

  generate
    if (IN_W > OUT_W) begin : g_sat
      // In range exactly when every bit from the output sign bit upward agrees.
      logic [IN_W-OUT_W:0] top_bits;
      assign top_bits = din_i[IN_W-1:OUT_W-1];

      always_comb begin
        clip_o = !((top_bits == '0) || (top_bits == '1));
        if (clip_o) begin
          dout_o = din_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
          dout_o = din_i[OUT_W-1:0];
        end
      end
    end else begin : g_ext
      assign dout_o = OUT_W'($signed(din_i));
      assign clip_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/band_mixer.sv
// Serially sums one frame of amplified band samples, scales by SHIFT and
// saturates to the output width, presented on a valid/ready handshake.
module band_mixer #(
  parameter int unsigned N_BANDS = eq_pkg::N_BANDS,
  parameter int unsigned IN_W    = eq_pkg::AMP_W,
  parameter int unsigned OUT_W   = eq_pkg::SAMPLE_W,
  parameter int unsigned SHIFT   = eq_pkg::clog2(eq_pkg::N_BANDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_BANDS*IN_W-1:0] bands,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_sample,
  output logic                    clip
);

  import eq_pkg::*;

  localparam int unsigned IDX_W = clog2(N_BANDS);
  localparam int unsigned ACC_W = IN_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BANDS - 1);

  mix_state_e                state_q, state_d;
  logic [N_BANDS*IN_W-1:0]   frame_q, frame_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [OUT_W-1:0]          sample_q, sample_d;
  logic                      clip_q, clip_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;

  logic [IN_W-1:0]           band_cur;
  logic signed [ACC_W-1:0]   band_sext;
  logic signed [ACC_W-1:0]   total_s;
  logic signed [ACC_W-1:0]   scaled_s;
  logic [OUT_W-1:0]          sat_val;
  logic                      sat_clip;

  assign band_cur  = frame_q[idx_q*IN_W +: IN_W];
  assign band_sext = {{(ACC_W-IN_W){band_cur[IN_W-1]}}, band_cur};
  assign total_s   = acc_q + band_sext;
  assign scaled_s  = total_s >>> SHIFT;

  sat_trunc #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .din_i  (scaled_s),
    .dout_o (sat_val),
    .clip_o (sat_clip)
  );

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    sample_d    = sample_q;
    clip_d      = clip_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      MIX_IDLE: begin
        if (in_valid && in_ready_q) begin
          frame_d    = bands;
          acc_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = MIX_ACCUM;
        end
      end
      MIX_ACCUM: begin
        acc_d = total_s;
        idx_d = idx_q + 1'b1;
        // Last band: the final sum is scaled and saturated in the same cycle.
        if (idx_q == LAST_IDX) begin
          sample_d    = sat_val;
          clip_d      = sat_clip;
          out_valid_d = 1'b1;
          state_d     = MIX_DONE;
        end
      end
      MIX_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = MIX_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = MIX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= MIX_IDLE;
      frame_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      sample_q    <= '0;
      clip_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      sample_q    <= sample_d;
      clip_q      <= clip_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sample = sample_q;
  assign clip       = clip_q;

endmodule

// File: tb/tb_band_mixer.sv
// Directed self-checking bench for band_mixer with hand-computed results.
module tb_band_mixer;

  localparam int NB = 8;
  localparam int IW = 18;
  localparam int OW = 16;
  localparam int BW = NB * IW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] bands;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sample;
  logic          clip;

  int n_cmp;
  int n_bad;

  band_mixer #(
    .N_BANDS (NB),
    .IN_W    (IW),
    .OUT_W   (OW),
    .SHIFT   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bands      (bands),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .clip       (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pack_all(input int v);
    logic [BW-1:0] p;
    p = '0;
    for (int i = 0; i < NB; i++) p[i*IW +: IW] = v[IW-1:0];
    return p;
  endfunction

  function automatic logic [BW-1:0] pack_b0(input int v);
    logic [BW-1:0] p;
    p = '0;
    p[IW-1:0] = v[IW-1:0];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a frame, let it be accepted, then count cycles until out_valid.
  task automatic run_frame(input logic [BW-1:0] b, output int lat);
    int guard;
    bands    = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 30) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (out_valid) begin
        lat = k - 1;
        break;
      end
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input int lat,
                              input logic signed [OW-1:0] exp_s, input logic exp_c);
    n_cmp++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want 8", name, lat);
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s out_valid: got %b want 1", name, out_valid);
    end
    n_cmp++;
    if (out_sample !== exp_s) begin
      n_bad++;
      $display("FAIL %s out_sample: got %0d want %0d", name, $signed(out_sample), exp_s);
    end
    n_cmp++;
    if (clip !== exp_c) begin
      n_bad++;
      $display("FAIL %s clip: got %b want %b", name, clip, exp_c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bands = '0;
    tick(); tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (out_sample !== 16'sd0) begin n_bad++; $display("FAIL reset out_sample: got %0d want 0", $signed(out_sample)); end
    n_cmp++;
    if (clip !== 1'b0) begin n_bad++; $display("FAIL reset clip: got %b want 0", clip); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_unity();
    int lat;
    run_frame(pack_all(1000), lat);
    check_result("unity", lat, 16'sd1000, 1'b0);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL unity valid_drop: got %b want 0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL unity in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_band();
    int lat;
    run_frame(pack_b0(800), lat);
    check_result("band0_800", lat, 16'sd100, 1'b0);
    tick();
    run_frame(pack_b0(-1), lat);
    check_result("band0_neg1_floor", lat, -16'sd1, 1'b0);
    tick();
  endtask

  task automatic test_saturate();
    int lat;
    run_frame(pack_all(131071), lat);
    check_result("sat_pos", lat, 16'sh7fff, 1'b1);
    tick();
    run_frame(pack_all(-131072), lat);
    check_result("sat_neg", lat, 16'sh8000, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    run_frame(pack_all(1000), lat);
    check_result("bp_first", lat, 16'sd1000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bands    = pack_all(-7000 + c * 311);
      in_valid = c[0];
      tick();
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold valid c=%0d: got %b want 1", c, out_valid); end
      n_cmp++;
      if (out_sample !== 16'sd1000) begin n_bad++; $display("FAIL bp_hold sample c=%0d: got %0d want 1000", c, $signed(out_sample)); end
      n_cmp++;
      if (clip !== 1'b0) begin n_bad++; $display("FAIL bp_hold clip c=%0d: got %b want 0", c, clip); end
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold in_ready c=%0d: got %b want 0", c, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release valid: got %b want 0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release in_ready: got %b want 1", in_ready); end
    tick(); tick(); tick();
    tick(); tick(); tick(); tick(); tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_capture valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bands    = pack_all(1000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst valid: got %b want 0", out_valid); end
    n_cmp++;
    if (out_sample !== 16'sd0) begin n_bad++; $display("FAIL midrst sample: got %0d want 0", $signed(out_sample)); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst in_ready: got %b want 1", in_ready); end
    run_frame(pack_all(8), lat);
    check_result("after_midrst", lat, 16'sd8, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    logic signed [OW-1:0] s1, s2;
    t1 = -1; t2 = -1; s1 = '0; s2 = '0;
    out_ready = 1'b1;
    bands     = pack_all(1000);
    in_valid  = 1'b1;
    tick();
    bands = pack_b0(-4000);
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (out_valid && t1 < 0) begin
        t1 = t; s1 = out_sample;
      end else if (out_valid && t2 < 0) begin
        t2 = t; s2 = out_sample;
        break;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (t1 !== 8) begin n_bad++; $display("FAIL b2b first_time: got %0d want 8", t1); end
    n_cmp++;
    if (s1 !== 16'sd1000) begin n_bad++; $display("FAIL b2b first_sample: got %0d want 1000", s1); end
    n_cmp++;
    if (t2 !== 18) begin n_bad++; $display("FAIL b2b second_time: got %0d want 18", t2); end
    n_cmp++;
    if (s2 !== -16'sd500) begin n_bad++; $display("FAIL b2b second_sample: got %0d want -500", s2); end
    n_cmp++;
    if (clip !== 1'b0) begin n_bad++; $display("FAIL b2b clip: got %b want 0", clip); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_unity();
    test_single_band();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/band_mixer.md
Name: band_mixer

Overview:
Downstream stage of the eight per-band gain amplifiers in the equalizer output path. Takes one packed frame of amplified band samples per audio sample period and accumulates the bands serially, one band per clock. Scales the sum by an arithmetic right shift and saturates it to the DAC/output sample width. Presents the result on a valid/ready handshake with a clip indication.

Parameters:
N_BANDS, 8, number of bands summed per frame (power of two, ≥2)
IN_W, 18, signed width of each amplified band sample (16-bit sample × gain ≤3)
OUT_W, 16, signed width of mixed output sample
SHIFT, 3, arithmetic right shift applied to the full sum (log2 N_BANDS = unity-average)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  band frame available
in_ready  output  1  block can accept a frame
bands  input  N_BANDS*IN_W  packed signed band samples; band i at bits [i*IN_W +: IN_W], band 0 in the LSBs
out_valid  output  1  mixed sample valid
out_ready  input  1  consumer accepts mixed sample
out_sample  output  OUT_W  signed mixed, scaled, saturated sample
clip  output  1  high with out_valid when the current out_sample was saturated

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst sampled low at a rising edge forces state IDLE, accumulator = 0, band index = 0, out_valid = 0, out_sample = 0, clip = 0, and frame register = 0. Any partial sum is discarded, including mid-ACCUM or mid-DONE.
- Accumulator width ACC_W = IN_W + clog2(N_BANDS), which is 21 with the defaults. Each band is sign-extended before it is added. No overflow is possible inside the accumulator.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready, the block registers bands into the frame register, clears the accumulator, sets idx = 0, and moves to ACCUM.
- ACCUM: in_ready = 0 and in_valid is ignored. Each cycle, acc <= acc + sext(frame[idx]) and idx increments. On the cycle with idx == N_BANDS-1, the block does the following:
  - forms total = acc + sext(frame[idx]);
  - computes scaled = total >>> SHIFT (arithmetic, floor toward −∞);
  - registers out_sample <= sat(scaled) and clip <= (scaled out of range);
  - moves to DONE.
- Saturation range: max 2^(OUT_W-1)-1 = 32767, min −2^(OUT_W-1) = −32768. Values in range pass unchanged with clip = 0.
- DONE: out_valid = 1. out_sample and clip are held stable while out_ready = 0. On out_ready = 1, the block moves to IDLE, and out_valid drops in the following cycle.
- in_ready = 0 in DONE. The block does not accept a new frame in the same cycle as the output handshake.
- Latency: frame accepted at edge E0 → out_valid high after edge E0+N_BANDS (8 cycles). Minimum frame period is N_BANDS+2 = 10 cycles, which is far below the audio sample period.
- A band at gain 0 contributes 0. No special-casing.
- frame is frozen from accept until DONE exits, so later changes on bands have no effect.

Decomposition:
- Shared package eq_pkg holds the following:
  - N_BANDS, SAMPLE_W (16), GAIN_MAX (3), and AMP_W (18) constants;
  - the mixer state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2);
  - a clog2 helper for ACC_W.
- One sub-module is natural: sat_trunc. It is combinational, with parameters IN_W=ACC_W and OUT_W, and outputs the saturated value plus a clipped flag. The amplifier stage can reuse it later.
- The FSM, index counter, and accumulator stay in band_mixer.

Test Plan:
1. All bands = 1000, out_ready = 1 → total 8000, out_sample = 1000, clip = 0, out_valid exactly 8 cycles after the accept edge.
2. Band0 = 800, others 0; then band0 = −1, others 0 → 100 with clip = 0; then −1 (floor) with clip = 0.
3. All bands = 131071 → scaled 131071 → out_sample = 32767, clip = 1. All bands = −131072 → out_sample = −32768, clip = 1.
4. Backpressure: hold out_ready = 0 for 5 cycles after out_valid rises, toggling bands and pulsing in_valid → out_sample and clip are held, in_ready = 0, and no new frame is captured. Then out_ready = 1 → IDLE, with in_ready = 1 next cycle.
5. Reset mid-operation: pull rst low for 1 cycle at the 4th ACCUM cycle → next cycle IDLE with out_valid = 0 and out_sample = 0. A following frame of all 8 gives out_sample = 8, with no residue from the aborted frame.
6. Back-to-back frames with in_valid held high → frames accepted every 10 cycles. Each result matches its own frame: 1000 then −500 with mixed-sign bands (e.g. bands = {−4000, 0,…,0}).
